// File: rtl/chacha_stream_ctrl.sv
// Bit-serial stream cipher controller: XORs plaintext bits with 16-bit keystream
// blocks fetched by block counter, with valid/ready handshakes on both sides.
module chacha_stream_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       cfg_init_ctr,
  input  logic [LEN_W-1:0] cfg_len,
  output logic [1:0]       ksg_ctr,
  input  logic [15:0]      ksg_keystream,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             ks_reuse
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       ctr_reg;
  logic [1:0]       init_ctr_reg;
  logic [LEN_W-1:0] rem_reg;
  logic [3:0]       idx_reg;
  logic [15:0]      ks_reg;
  logic             out_valid_reg;
  logic             out_bit_reg;
  logic             ks_reuse_reg;

  logic             xfer;
  logic             last_bit;
  logic             wrap;
  logic [1:0]       ctr_inc;

  assign xfer     = in_valid && in_ready;
  assign last_bit = (rem_reg == LEN_W'(1));
  assign wrap     = (idx_reg == 4'd15);
  assign ctr_inc  = ctr_reg + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // abort outranks every transition, including a start seen in IDLE
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_next = (cfg_len == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD:   state_next = S_STREAM;
        S_STREAM: begin
          if (xfer) begin
            if (last_bit) begin
              state_next = S_DRAIN;
            end else if (wrap) begin
              state_next = S_LOAD;
            end
          end
        end
        S_DRAIN: begin
          if (!out_valid_reg) begin
            state_next = S_DONE;
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state_reg != S_IDLE);
    done     = (state_reg == S_DONE);
    in_ready = (state_reg == S_STREAM) && (!out_valid_reg || out_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_reg       <= 2'd0;
      init_ctr_reg  <= 2'd0;
      rem_reg       <= '0;
      idx_reg       <= 4'd0;
      ks_reg        <= 16'd0;
      out_valid_reg <= 1'b0;
      out_bit_reg   <= 1'b0;
      ks_reuse_reg  <= 1'b0;
    end else if (abort) begin
      out_valid_reg <= 1'b0;
    end else begin
      if (state_reg == S_IDLE && start) begin
        ctr_reg      <= cfg_init_ctr;
        init_ctr_reg <= cfg_init_ctr;
        rem_reg      <= cfg_len;
        ks_reuse_reg <= 1'b0;
      end
      if (state_reg == S_LOAD) begin
        ks_reg  <= ksg_keystream;
        idx_reg <= 4'd0;
      end
      if (xfer) begin
        out_bit_reg   <= in_bit ^ ks_reg[4'd15 - idx_reg];
        out_valid_reg <= 1'b1;
        idx_reg       <= idx_reg + 4'd1;
        rem_reg       <= rem_reg - LEN_W'(1);
        // the final bit of a message never advances the counter
        if (!last_bit && wrap) begin
          ctr_reg <= ctr_inc;
          if (ctr_inc == init_ctr_reg) begin
            ks_reuse_reg <= 1'b1;
          end
        end
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign ksg_ctr   = ctr_reg;
  assign out_valid = out_valid_reg;
  assign out_bit   = out_bit_reg;
  assign ks_reuse  = ks_reuse_reg;

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Directed bench for chacha_stream_ctrl: hand-computed ciphertext, counter
// sequence, timing and abort/reset behaviour.
module tb_chacha_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  cfg_init_ctr = 2'd0;
  logic [7:0]  cfg_len = 8'd0;
  logic [1:0]  ksg_ctr;
  logic [15:0] ksg_keystream;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_bit;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        ks_reuse;

  logic [15:0] ks_tab [4];
  int checks = 0;
  int failures = 0;

  chacha_stream_ctrl #(.LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_init_ctr(cfg_init_ctr), .cfg_len(cfg_len),
    .ksg_ctr(ksg_ctr), .ksg_keystream(ksg_keystream),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .out_valid(out_valid), .out_bit(out_bit), .out_ready(out_ready),
    .busy(busy), .done(done), .ks_reuse(ks_reuse)
  );

  always #5 clk = ~clk;

  // keystream generator model: a lookup per block counter
  always_comb ksg_keystream = ks_tab[ksg_ctr];

  // monitor state, written only by the negedge monitor
  int           cyc = 0;
  int           xfer_cnt = 0;
  int           got_cnt = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;
  int           last_acc_cyc = 0;
  int           rise_cnt = 0;
  logic [127:0] got_vec = '0;
  logic         prev_valid = 1'b0;
  logic         reuse_at_done = 1'b0;
  int           xfer_cyc [1024];
  int           rise_cyc [1024];
  logic [1:0]   ctr_hist [1024];
  logic         reuse_hist [1024];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_valid && in_ready && xfer_cnt < 1024) begin
      xfer_cyc[xfer_cnt]   = cyc;
      ctr_hist[xfer_cnt]   = ksg_ctr;
      reuse_hist[xfer_cnt] = ks_reuse;
      xfer_cnt++;
    end
    if (out_valid && !prev_valid && rise_cnt < 1024) begin
      rise_cyc[rise_cnt] = cyc;
      rise_cnt++;
    end
    prev_valid = out_valid;
    if (out_valid && out_ready) begin
      got_vec      = {got_vec[126:0], out_bit};
      got_cnt++;
      last_acc_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc      = cyc;
      reuse_at_done = ks_reuse;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic [1:0] init, input logic [7:0] len);
    cfg_init_ctr = init;
    cfg_len      = len;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  // feeds nbits (first bit = MSB of the nbits-wide value) with optional sink stall
  task automatic stream(input int nbits, input logic [127:0] in_vec, input logic [127:0] exp_vec,
                        input int stall_at, input int stall_len);
    int   n = 0;
    int   budget = 0;
    logic xf;
    bit   stalled = 0;
    while (n < nbits && budget < 4 * nbits + 40) begin
      if (n == stall_at && !stalled && stall_len > 0) begin
        stalled   = 1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bit    = in_vec[nbits-1-n];
        for (int k = 0; k < stall_len; k++) begin
          #1;
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
          check("bp_out_bit", out_bit, exp_vec[nbits-stall_at]);
          tick();
        end
        out_ready = 1'b1;
      end
      in_bit   = in_vec[nbits-1-n];
      in_valid = 1'b1;
      #1;
      xf = in_ready;
      tick();
      budget++;
      if (xf) n++;
    end
    in_valid = 1'b0;
    check("stream_count", n, nbits);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    tick();
    tick();
    check(tag, done_cnt - d0, 1);
    $display("msg %s: done_pulses=%0d bits_out=%0d", tag, done_cnt - d0, got_cnt);
  endtask

  initial begin
    int x0, g0, r0, d0;
    for (int i = 0; i < 4; i++) ks_tab[i] = 16'hA5C3;

    // reset state
    repeat (3) tick();
    check("rst_outputs", {busy, done, out_valid, out_bit, in_ready, ksg_ctr, ks_reuse}, 0);
    reset = 1'b0;

    // basic message: A5C3 ^ 1111 -> 0101
    x0 = xfer_cnt; g0 = got_cnt; r0 = rise_cnt;
    start_msg(2'd0, 8'd4);
    check("basic_busy", busy, 1);
    stream(4, 128'hF, 128'h5, 0, 0);
    wait_done("basic_done", 50);
    check("basic_bits", got_vec[3:0], 4'b0101);
    check("basic_count", got_cnt - g0, 4);
    check("basic_done_lat", done_cyc - last_acc_cyc, 2);
    check("basic_out_lat", rise_cyc[r0] - xfer_cyc[x0], 1);

    // block crossing: FFFF then 0000
    ks_tab[2] = 16'hFFFF;
    ks_tab[3] = 16'h0000;
    x0 = xfer_cnt; g0 = got_cnt;
    start_msg(2'd2, 8'd20);
    stream(20, 128'h0, 128'hFFFF0, 0, 0);
    wait_done("cross_done", 60);
    check("cross_bits", got_vec[19:0], 20'hFFFF0);
    check("cross_ctr0", ctr_hist[x0], 2);
    check("cross_ctr1", ctr_hist[x0+16], 3);
    check("cross_span", xfer_cyc[x0+19] - xfer_cyc[x0], 20);

    // backpressure: 10110010 ^ 3C -> 10001110, sink stalls after 3 bits
    ks_tab[0] = 16'h3C5A;
    g0 = got_cnt;
    start_msg(2'd0, 8'd8);
    stream(8, 128'hB2, 128'h8E, 3, 5);
    wait_done("bp_done", 60);
    check("bp_bits", got_vec[7:0], 8'h8E);
    check("bp_count", got_cnt - g0, 8);

    // counter wrap: blocks 1,2,3,0,1 with zero plaintext
    ks_tab[0] = 16'h0F0F; ks_tab[1] = 16'h1234; ks_tab[2] = 16'hBEEF; ks_tab[3] = 16'h5A5A;
    x0 = xfer_cnt;
    start_msg(2'd1, 8'd80);
    stream(80, 128'h0, 128'h0, 0, 0);
    wait_done("wrap_done", 200);
    check("wrap_bits", got_vec[79:0], {16'h1234, 16'hBEEF, 16'h5A5A, 16'h0F0F, 16'h1234});
    check("wrap_ctr_seq", {ctr_hist[x0], ctr_hist[x0+16], ctr_hist[x0+32], ctr_hist[x0+48], ctr_hist[x0+64]},
          10'b01_10_11_00_01);
    check("wrap_reuse_bit64", reuse_hist[x0+63], 0);
    check("wrap_reuse_bit65", reuse_hist[x0+64], 1);
    check("wrap_reuse_at_done", reuse_at_done, 1);
    check("wrap_reuse_after", ks_reuse, 1);

    // abort after counter reuse keeps the flag
    d0 = done_cnt;
    start_msg(2'd3, 8'd70);
    check("reab_reuse_clr", ks_reuse, 0);
    stream(66, 128'h0, 128'h0, 0, 0);
    out_ready = 1'b0;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    check("reab_busy", busy, 0);
    check("reab_out_valid", out_valid, 0);
    check("reab_reuse_kept", ks_reuse, 1);
    out_ready = 1'b1;

    // abort at bit 7, then a zero-length message
    start_msg(2'd0, 8'd20);
    stream(7, 128'h0, 128'h0, 0, 0);
    out_ready = 1'b0;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 0);
    out_ready = 1'b1;
    repeat (3) tick();
    check("abort_no_done", done_cnt - d0, 0);
    x0 = xfer_cnt;
    start_msg(2'd0, 8'd0);
    check("zero_done_hi", done, 1);
    tick();
    check("zero_done_lo", {done, busy}, 2'b00);
    check("zero_no_data", xfer_cnt - x0, 0);
    $display("msg zero_len: done_pulses=%0d", done_cnt - d0);

    // start together with abort in IDLE stays idle
    cfg_len = 8'd4;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    start   = 1'b0;
    abort   = 1'b0;
    check("start_abort_idle", busy, 0);

    // reset in the middle of a message
    for (int i = 0; i < 4; i++) ks_tab[i] = 16'hA5C3;
    d0 = done_cnt;
    start_msg(2'd2, 8'd20);
    stream(5, 128'h0, 128'h0, 0, 0);
    reset = 1'b1;
    #1;
    check("midrst_outputs", {busy, done, out_valid, out_bit, in_ready, ksg_ctr, ks_reuse}, 0);
    tick();
    reset = 1'b0;
    check("midrst_no_done", done_cnt - d0, 0);
    g0 = got_cnt;
    start_msg(2'd0, 8'd4);
    check("midrst_accept", busy, 1);
    stream(4, 128'hF, 128'h5, 0, 0);
    wait_done("midrst_done", 50);
    check("midrst_bits", got_vec[3:0], 4'b0101);
    check("midrst_count", got_cnt - g0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/chacha_stream_ctrl.md
CHACHA_STREAM_CTRL -- requirements
Module: chacha_stream_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the message-length field in bits.
REQ-002 SHALL have port clk  input  1: rising-edge clock.
REQ-003 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1: one-cycle request to begin a message; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1: synchronous cancel of the current message.
REQ-006 SHALL have port cfg_init_ctr  input  2: initial block counter, captured on an accepted start.
REQ-007 SHALL have port cfg_len  input  LEN_W: message length in bits, captured on an accepted start.
REQ-008 SHALL have port ksg_ctr  output  2: block counter driven to the keystream generator.
REQ-009 SHALL have port ksg_keystream  input  16: combinational keystream block for ksg_ctr.
REQ-010 SHALL have port in_valid  input  1: plaintext bit valid.
REQ-011 SHALL have port in_bit  input  1: plaintext bit.
REQ-012 SHALL have port in_ready  output  1: controller accepts in_bit this cycle.
REQ-013 SHALL have port out_valid  output  1: ciphertext bit valid.
REQ-014 SHALL have port out_bit  output  1: ciphertext bit.
REQ-015 SHALL have port out_ready  input  1: sink accepts out_bit this cycle.
REQ-016 SHALL have port busy  output  1: high in every state except IDLE.
REQ-017 SHALL have port done  output  1: one-cycle pulse at message completion.
REQ-018 SHALL have port ks_reuse  output  1: sticky flag set when the block counter returns to the captured initial counter value within one message.

Function
REQ-019 SHALL implement the states IDLE, LOAD, STREAM, DRAIN and DONE.
REQ-020 IDLE + start: SHALL capture cfg_init_ctr into the block counter and cfg_len into the remaining count, clear ks_reuse, and go to LOAD; if cfg_len==0, SHALL go directly to DONE.
REQ-021 LOAD, one cycle: SHALL register ksg_keystream into ks_reg, set bit index to 0, and go to STREAM.
REQ-022 ksg_ctr SHALL equal the block counter register at all times.
REQ-023 in_ready SHALL be state==STREAM && (!out_valid || out_ready).
REQ-024 A transfer SHALL occur on in_valid && in_ready.
REQ-025 On a transfer, out_bit SHALL be loaded with in_bit XOR ks_reg[15-index] (MSB first), out_valid SHALL be set, the index SHALL be incremented and the remaining count SHALL be decremented.
REQ-026 out_valid SHALL clear on out_valid && out_ready when no new transfer occurs in the same cycle.
REQ-027 out_bit and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-028 On the transfer where the remaining count reaches 0, the state SHALL go to DRAIN; this takes priority over an index wrap.
REQ-029 Otherwise, on the transfer at index 15, the block counter SHALL increment mod 4, the index SHALL wrap to 0 and the state SHALL go to LOAD (one-cycle bubble, in_ready low).
REQ-030 ks_reuse SHALL set when the incremented counter equals the captured cfg_init_ctr.
REQ-031 DRAIN SHALL wait until out_valid==0 (the last bit has been accepted), then go to DONE.
REQ-032 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-033 start SHALL be ignored in every state except IDLE.
REQ-034 abort in any non-IDLE state SHALL return to IDLE on the next edge and clear out_valid without emitting done; ks_reuse SHALL be retained.
REQ-035 abort SHALL take priority over every other transition.
REQ-036 Simultaneous start and abort in IDLE: abort SHALL win and the controller SHALL stay in IDLE.
REQ-037 Latency from an accepted input bit to out_valid SHALL be 1 cycle.
REQ-038 Sustained throughput SHALL be 16 bits per 17 cycles when out_ready is held high.

Reset
REQ-039 While reset is high, the state SHALL be IDLE and ksg_ctr, ks_reg, index, remaining count, out_valid, out_bit, in_ready, busy, done and ks_reuse SHALL all be 0.
REQ-040 Reset asserted mid-message SHALL abandon the message with no done pulse.
REQ-041 After reset deasserts, the first start SHALL be accepted on the following rising edge.

Verification
REQ-042 Basic message: cfg_init_ctr=0, cfg_len=4, ksg_keystream=16'hA5C3, in bits 1,1,1,1 with out_ready=1 -> out bits 0,1,0,1; done pulses 2 cycles after the last output is accepted.
REQ-043 Block crossing: cfg_len=20, init 2, bench model returns 16'hFFFF for ctr 2 and 16'h0000 for ctr 3, all-zero input -> 16 ones then 4 zeros; ksg_ctr reads 3 after bit 16; in_ready is low for 1 LOAD cycle.
REQ-044 Backpressure: out_ready=0 for 5 cycles mid-stream -> in_ready stays low, out_bit is stable, and no bit is lost or duplicated.
REQ-045 Counter wrap: init 1, cfg_len=80 -> ksg_ctr follows 1,2,3,0,1; ks_reuse sets at the 65th bit boundary and stays set through done.
REQ-046 Abort and zero length: abort at bit 7 -> IDLE next cycle, out_valid=0, no done; a following start with cfg_len=0 -> done pulses with no data transferred.
REQ-047 Reset mid-STREAM: all outputs read 0 and the next start is accepted normally.
